// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read/write controllers:
// default widths, small counter type and Gray-code conversions.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef logic [1:0] occ_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready output stream of the FIFO read side.
interface fifo_rd_ctrl_if #(
  parameter int Data_Width = fifo_pkg::DATA_WIDTH_DEF
) ();

  logic [Data_Width-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input  m_ready);
  modport slave  (input  m_data, input  m_valid, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry FIFO-ordered output buffer that absorbs the memory read latency
// so a stalled consumer never causes a fetched word to be dropped.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [Data_Width-1:0] wr_data,
  input  logic                  pop,
  output logic                  m_valid,
  output logic [Data_Width-1:0] m_data,
  output occ_t                  count
);

  logic [Data_Width-1:0] head_q, head_d;
  logic [Data_Width-1:0] tail_q, tail_d;
  occ_t                  cnt_q, cnt_d;

  // head changes only when empty or on a pop, keeping m_data stable under stall
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (wr) begin
          head_d = wr_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (wr && pop) begin
          head_d = wr_data;
        end else if (wr) begin
          tail_d = wr_data;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (wr) begin
            tail_d = wr_data;
          end else begin
            cnt_d  = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = head_q;
  assign count   = cnt_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: empty detection, memory fetch,
// Gray read pointer export and a latency-absorbing valid/ready output stream.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int Addr_Width = ADDR_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [Addr_Width:0]   rq2_wptr,
  input  logic [Data_Width-1:0] r_data,
  output logic [Addr_Width-1:0] r_addr,
  output logic                  r_en,
  output logic                  rempty,
  output logic [Addr_Width:0]   rptr,
  fifo_rd_ctrl_if.master        m_if
);

  localparam int PW = Addr_Width + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rempty_q, rempty_d;
  occ_t          occ_q, occ_d;
  logic          fetch_q, fetch_d;
  logic          pop;
  logic          rd_en;
  occ_t          buf_count;

  // Fetch stage: occ counts the in-flight word plus buffered words, so a
  // pop frees a slot in the same cycle and 1 word/cycle is sustained.
  always_comb begin
    pop      = m_if.m_valid && m_if.m_ready;
    rd_en    = !rempty_q && ((occ_q < 2'd2) || pop);
    rbin_d   = rbin_q + PW'(rd_en);
    rptr_d   = PW'(bin2gray(32'(rbin_d)));
    rempty_d = (rptr_d == rq2_wptr);
    occ_d    = occ_q + occ_t'(rd_en) - occ_t'(pop);
    fetch_d  = rd_en;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      occ_q    <= 2'd0;
      fetch_q  <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      occ_q    <= occ_d;
      fetch_q  <= fetch_d;
    end
  end

  // Memory data stage: r_data belongs to the fetch issued one cycle earlier.
  fifo_rd_skid #(
    .Data_Width (Data_Width)
  ) u_skid (
    .clk     (rclk),
    .rst     (rrst),
    .wr      (fetch_q),
    .wr_data (r_data),
    .pop     (pop),
    .m_valid (m_if.m_valid),
    .m_data  (m_if.m_data),
    .count   (buf_count)
  );

  assign r_addr = rbin_q[Addr_Width-1:0];
  assign r_en   = rd_en;
  assign rempty = rempty_q;
  assign rptr   = rptr_q;

endmodule
